id_hazard_sb: RTL and testbench



---
 rtl/id_pkg.sv | 19 +
 rtl/id_hazard_sb_if.sv | 31 +++
 rtl/id_rsr.sv | 62 ++++++
 rtl/id_hazard_sb.sv | 60 ++++++
 tb/tb_id_hazard_sb.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// id_pkg: shared encodings and default latencies for the decode-stage hazard scoreboard.
package id_pkg;
  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_LOAD = 2'd1,
    UNIT_MULT = 2'd2,
    UNIT_ALT  = 2'd3
  } unit_e;
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_RAW    = 2'd1,
    CAUSE_WAW    = 2'd2,
    CAUSE_STRUCT = 2'd3
  } cause_e;
  localparam int LAT_ALU_D  = 1;
  localparam int LAT_LOAD_D = 3;
  localparam int LAT_MULT_D = 10;
  localparam int FWD_SLOT_D = 1;
endpackage

// File: rtl/id_hazard_sb_if.sv
// id_hazard_sb_if: decode request, issue/stall status and predicted write-back.
interface id_hazard_sb_if;
  logic       id_valid;
  logic       id_flush;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_use;
  logic       id_rt_use;
  logic       id_src_fp;
  logic       id_wr_en;
  logic [4:0] id_wr_reg;
  logic       id_wr_fp;
  logic [1:0] id_unit;
  logic       id_issue;
  logic       id_stall;
  logic [1:0] stall_cause;
  logic       mult_busy;
  logic       wb_valid;
  logic [4:0] wb_reg;
  logic       wb_fp;
  modport master (
    output id_valid, id_flush, id_rs, id_rt, id_rs_use, id_rt_use, id_src_fp,
           id_wr_en, id_wr_reg, id_wr_fp, id_unit,
    input  id_issue, id_stall, stall_cause, mult_busy, wb_valid, wb_reg, wb_fp
  );
  modport slave (
    input  id_valid, id_flush, id_rs, id_rt, id_rs_use, id_rt_use, id_src_fp,
           id_wr_en, id_wr_reg, id_wr_fp, id_unit,
    output id_issue, id_stall, stall_cause, mult_busy, wb_valid, wb_reg, wb_fp
  );
endinterface

// File: rtl/id_rsr.sv
// id_rsr: result shift register with post-shift source/destination match vectors.
module id_rsr
  import id_pkg::*;
#(
  parameter int DEPTH = LAT_MULT_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_slot,
  input  logic [4:0]               wr_reg,
  input  logic                     wr_fp,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic                     rs_use,
  input  logic                     rt_use,
  input  logic                     src_fp,
  input  logic [4:0]               dst_reg,
  input  logic                     dst_fp,
  output logic [DEPTH-1:0]         post_valid,
  output logic [DEPTH-1:0]         raw_vec,
  output logic [DEPTH-1:0]         waw_vec,
  output logic                     wb_valid,
  output logic [4:0]               wb_reg,
  output logic                     wb_fp
);
  logic [DEPTH-1:0]      v, f, pf, wr_hot;
  logic [DEPTH-1:0][4:0] r, pr;
  logic                  rs_ok, rt_ok;
  // integer r0 is hardwired, so it never counts as a live source
  assign rs_ok = rs_use & (src_fp | (rs != 5'd0));
  assign rt_ok = rt_use & (src_fp | (rt != 5'd0));
  assign post_valid = {1'b0, v[DEPTH-1:1]};
  assign wr_hot = wr_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_slot) : '0;
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k < DEPTH - 1) begin : g_mid
      assign pr[k] = r[k+1];
      assign pf[k] = f[k+1];
    end else begin : g_top
      assign pr[k] = '0;
      assign pf[k] = 1'b0;
    end
    assign raw_vec[k] = post_valid[k] & (pf[k] == src_fp) &
                        ((rs_ok & (pr[k] == rs)) | (rt_ok & (pr[k] == rt)));
    assign waw_vec[k] = post_valid[k] & (pf[k] == dst_fp) & (pr[k] == dst_reg);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      f <= '0;
      r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        v[i] <= wr_hot[i] | post_valid[i];
        r[i] <= wr_hot[i] ? wr_reg : pr[i];
        f[i] <= wr_hot[i] ? wr_fp : pf[i];
      end
    end
  assign wb_valid = v[0];
  assign wb_reg   = r[0];
  assign wb_fp    = f[0];
endmodule

// File: rtl/id_hazard_sb.sv
// id_hazard_sb: decode-stage scoreboard deciding issue vs stall (structural > RAW > WAW).
module id_hazard_sb
  import id_pkg::*;
#(
  parameter int LAT_ALU  = LAT_ALU_D,
  parameter int LAT_LOAD = LAT_LOAD_D,
  parameter int LAT_MULT = LAT_MULT_D,
  parameter int FWD_SLOT = FWD_SLOT_D
) (
  input logic           clk,
  input logic           rst_n,
  id_hazard_sb_if.slave bus
);
  localparam int SW = $clog2(LAT_MULT);
  logic [SW-1:0]       lat_m1, mult_cnt;
  logic [LAT_MULT-1:0] post_valid, raw_vec, waw_vec;
  logic                live, is_mult, wr_req, struct_haz, raw, waw, hazard;
  assign is_mult = bus.id_unit == UNIT_MULT;
  assign lat_m1 = bus.id_unit == UNIT_LOAD ? SW'(LAT_LOAD - 1) :
                  is_mult                  ? SW'(LAT_MULT - 1) : SW'(LAT_ALU - 1);
  assign wr_req = bus.id_wr_en & (bus.id_wr_fp | (bus.id_wr_reg != 5'd0));
  // a non-writing instruction claims no write-back slot and cannot reorder writes
  assign struct_haz = (wr_req & post_valid[lat_m1]) | (is_mult & bus.mult_busy);
  assign raw = |(raw_vec & ({LAT_MULT{1'b1}} << FWD_SLOT));
  assign waw = wr_req & |(waw_vec & ({LAT_MULT{1'b1}} << lat_m1));
  assign hazard = struct_haz | raw | waw;
  assign live = bus.id_valid & ~bus.id_flush;
  assign bus.id_issue = live & ~hazard;
  assign bus.id_stall = live & hazard;
  assign bus.stall_cause = !live      ? CAUSE_NONE   :
                           struct_haz ? CAUSE_STRUCT :
                           raw        ? CAUSE_RAW    :
                           waw        ? CAUSE_WAW    : CAUSE_NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mult_cnt <= '0;
    else if (bus.id_issue & is_mult) mult_cnt <= SW'(LAT_MULT - 1);
    else if (mult_cnt != '0) mult_cnt <= mult_cnt - 1'b1;
  assign bus.mult_busy = mult_cnt != '0;
  id_rsr #(.DEPTH(LAT_MULT)) u_rsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.id_issue & wr_req),
    .wr_slot    (lat_m1),
    .wr_reg     (bus.id_wr_reg),
    .wr_fp      (bus.id_wr_fp),
    .rs         (bus.id_rs),
    .rt         (bus.id_rt),
    .rs_use     (bus.id_rs_use),
    .rt_use     (bus.id_rt_use),
    .src_fp     (bus.id_src_fp),
    .dst_reg    (bus.id_wr_reg),
    .dst_fp     (bus.id_wr_fp),
    .post_valid (post_valid),
    .raw_vec    (raw_vec),
    .waw_vec    (waw_vec),
    .wb_valid   (bus.wb_valid),
    .wb_reg     (bus.wb_reg),
    .wb_fp      (bus.wb_fp)
  );
endmodule

// File: tb/tb_id_hazard_sb.sv
// tb_id_hazard_sb: scenario tasks for issue/stall plus a write-back scoreboard.
module tb_id_hazard_sb;
  import id_pkg::*;
  typedef struct {
    int         due;
    logic [4:0] r;
    logic       fp;
  } wb_t;
  localparam logic [3:0] ISSUE = 4'b1000, NONE = 4'b0000, RAW = 4'b0101, WAW = 4'b0110, STR = 4'b0111;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0, mismatched = 0, cyc = 0;
  wb_t sb_q[$];
  wb_t exp_wb;
  logic [3:0] obs;
  id_hazard_sb_if bus ();
  id_hazard_sb dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign obs = {bus.id_issue, bus.id_stall, bus.stall_cause};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // write-back scoreboard: every cycle wb must equal the due entry or be idle
  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
      exp_wb = sb_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL wb_missed cyc %0d: reg %0d fp %0b never written back (due %0d)", cyc, exp_wb.r, exp_wb.fp, exp_wb.due);
    end
    compared++;
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      exp_wb = sb_q.pop_front();
      if ({bus.wb_valid, bus.wb_reg, bus.wb_fp} !== {1'b1, exp_wb.r, exp_wb.fp}) begin
        mismatched++;
        $display("FAIL wb_due cyc %0d: got v%0b r%0d fp%0b exp v1 r%0d fp%0b", cyc, bus.wb_valid, bus.wb_reg, bus.wb_fp, exp_wb.r, exp_wb.fp);
      end
    end else if (bus.wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL wb_spurious cyc %0d: got v%0b r%0d exp v0", cyc, bus.wb_valid, bus.wb_reg);
    end
  end
  function automatic int lat(logic [1:0] u);
    return u == 2'd1 ? 3 : u == 2'd2 ? 10 : 1;
  endfunction
  task automatic sb_push(logic [1:0] unit, logic [4:0] r, logic fp);
    wb_t e;
    int p;
    if (!fp && r == 5'd0) return;
    e.due = cyc + lat(unit);
    e.r = r;
    e.fp = fp;
    p = sb_q.size();
    while (p > 0 && sb_q[p-1].due > e.due) p--;
    sb_q.insert(p, e);
  endtask
  task automatic drive(logic [1:0] unit, logic [4:0] rs, logic rs_use, logic [4:0] rt, logic rt_use,
                       logic sfp, logic we, logic [4:0] wr, logic wfp);
    bus.id_valid = 1'b1;
    bus.id_flush = 1'b0;
    bus.id_unit = unit;
    bus.id_rs = rs;
    bus.id_rs_use = rs_use;
    bus.id_rt = rt;
    bus.id_rt_use = rt_use;
    bus.id_src_fp = sfp;
    bus.id_wr_en = we;
    bus.id_wr_reg = wr;
    bus.id_wr_fp = wfp;
  endtask
  task automatic idle();
    drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.id_valid = 1'b0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    idle();
    #2 rst_n = 1'b0;
    next();
    next();
    @(negedge clk);
    compared++;
    if ({bus.mult_busy, bus.wb_valid, bus.wb_reg, bus.wb_fp, obs} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_state got %h exp 000", {bus.mult_busy, bus.wb_valid, bus.wb_reg, bus.wb_fp, obs});
    end
    next();
    rst_n = 1'b1;
    drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL first_issue got %b exp %b", obs, ISSUE); end
    sb_push(2'd0, 5'd1, 1'b0);
    next();
    idle();
    repeat (2) next();
  endtask
  task automatic test_alu_fwd();
    drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL alu_r3 got %b exp %b", obs, ISSUE); end
    sb_push(2'd0, 5'd3, 1'b0);
    next();
    drive(2'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL alu_fwd_read got %b exp %b", obs, ISSUE); end
    sb_push(2'd0, 5'd8, 1'b0);
    next();
    idle();
    repeat (2) next();
  endtask
  task automatic test_raw_load();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_r5 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd5, 1'b0);
    next();
    drive(2'd0, 5'd9, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== RAW) begin mismatched++; $display("FAIL raw_stall got %b exp %b", obs, RAW); end
    next();
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL raw_release got %b exp %b", obs, ISSUE); end
    next();
    idle();
    repeat (3) next();
  endtask
  task automatic test_mult_struct();
    drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1);
    @(negedge clk);
    compared++;
    if ({bus.mult_busy, obs} !== {1'b0, ISSUE}) begin mismatched++; $display("FAIL mult_f2 got %b exp %b", {bus.mult_busy, obs}, {1'b0, ISSUE}); end
    sb_push(2'd2, 5'd2, 1'b1);
    next();
    drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      compared++;
      if ({bus.mult_busy, obs} !== {1'b1, STR}) begin mismatched++; $display("FAIL mult_busy_stall cycle %0d got %b exp %b", i, {bus.mult_busy, obs}, {1'b1, STR}); end
      next();
    end
    @(negedge clk);
    compared++;
    if ({bus.mult_busy, obs} !== {1'b0, ISSUE}) begin mismatched++; $display("FAIL mult_reissue got %b exp %b", {bus.mult_busy, obs}, {1'b0, ISSUE}); end
    sb_push(2'd2, 5'd3, 1'b1);
    next();
    idle();
    repeat (11) next();
  endtask
  task automatic test_waw();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_r7 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd7, 1'b0);
    next();
    drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== WAW) begin mismatched++; $display("FAIL waw_stall got %b exp %b", obs, WAW); end
    next();
    @(negedge clk);
    compared++;
    if (obs !== STR) begin mismatched++; $display("FAIL waw_slot_stall got %b exp %b", obs, STR); end
    next();
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL waw_release got %b exp %b", obs, ISSUE); end
    sb_push(2'd0, 5'd7, 1'b0);
    next();
    idle();
    repeat (3) next();
  endtask
  task automatic test_struct_slot();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_r4 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd4, 1'b0);
    next();
    idle();
    next();
    drive(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== STR) begin mismatched++; $display("FAIL slot_conflict got %b exp %b", obs, STR); end
    next();
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL slot_release got %b exp %b", obs, ISSUE); end
    sb_push(2'd0, 5'd6, 1'b0);
    next();
    idle();
    repeat (3) next();
  endtask
  task automatic test_flush_r0();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_f0 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd0, 1'b1);
    next();
    drive(2'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    bus.id_flush = 1'b1;
    @(negedge clk);
    compared++;
    if (obs !== NONE) begin mismatched++; $display("FAIL flush_quiet got %b exp %b", obs, NONE); end
    next();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_f1 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd1, 1'b1);
    next();
    drive(2'd0, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== RAW) begin mismatched++; $display("FAIL raw_fp got %b exp %b", obs, RAW); end
    next();
    drive(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL load_r0 got %b exp %b", obs, ISSUE); end
    sb_push(2'd1, 5'd0, 1'b0);
    next();
    drive(2'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL r0_no_hazard got %b exp %b", obs, ISSUE); end
    next();
    idle();
    repeat (4) next();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 5'(10 + i - 1), i != 0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(10 + i), 1'b0);
      @(negedge clk);
      compared++;
      if (obs !== ISSUE) begin mismatched++; $display("FAIL b2b_issue %0d got %b exp %b", i, obs, ISSUE); end
      sb_push(2'd0, 5'(10 + i), 1'b0);
      next();
    end
    idle();
    @(negedge clk);
    compared++;
    if (obs !== NONE) begin mismatched++; $display("FAIL idle_quiet got %b exp %b", obs, NONE); end
    next();
    repeat (2) next();
  endtask
  task automatic test_reset_mid_mult();
    drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    compared++;
    if (obs !== ISSUE) begin mismatched++; $display("FAIL mult_f5 got %b exp %b", obs, ISSUE); end
    next();
    idle();
    repeat (3) next();
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.mult_busy, bus.wb_valid} !== 2'b00) begin mismatched++; $display("FAIL reset_async got %b exp 00", {bus.mult_busy, bus.wb_valid}); end
    next();
    rst_n = 1'b1;
    drive(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
    @(negedge clk);
    compared++;
    if ({bus.mult_busy, obs} !== {1'b0, ISSUE}) begin mismatched++; $display("FAIL mult_after_reset got %b exp %b", {bus.mult_busy, obs}, {1'b0, ISSUE}); end
    sb_push(2'd2, 5'd6, 1'b1);
    next();
    idle();
    repeat (11) next();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_alu_fwd();
    test_raw_load();
    test_mult_struct();
    test_waw();
    test_struct_slot();
    test_flush_r0();
    test_back_to_back();
    test_reset_mid_mult();
    compared++;
    if (sb_q.size() != 0) begin mismatched++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
